// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bridge: funct3 codes, FSM states
// and the legality/alignment checks applied to an incoming request.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RMW  = 3'd2,
      ST_RESP = 3'd3,
      ST_ERR  = 3'd4
   } lsu_state_t;

   // funct3[1:0] encodes the access size for every legal load and store.
   function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3[1:0])
         2'b01:   return off[0];
         2'b10:   return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic illegal_funct3(input logic we, input logic [2:0] funct3);
      if (we)
         return !(funct3 inside {F3_B, F3_H, F3_W});
      else
         return !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends load data from a memory word and
// merges byte/halfword store data into the old word for read-modify-write.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_funct3,
   input  logic [15:0] i_wdata,
   output logic [31:0] o_load_data,
   output logic [31:0] o_store_word
);

   logic [7:0]  w_lane_byte;
   logic [15:0] w_lane_half;
   logic        w_is_byte;

   assign w_lane_byte = i_word[{i_off, 3'b000} +: 8];
   assign w_lane_half = i_off[1] ? i_word[31:16] : i_word[15:0];
   assign w_is_byte   = (i_funct3[1:0] == 2'b00);

   always_comb begin
      o_load_data = i_word;
      case (i_funct3)
         F3_B:    o_load_data = {{24{w_lane_byte[7]}}, w_lane_byte};
         F3_H:    o_load_data = {{16{w_lane_half[15]}}, w_lane_half};
         F3_BU:   o_load_data = {24'h0, w_lane_byte};
         F3_HU:   o_load_data = {16'h0, w_lane_half};
         default: o_load_data = i_word;
      endcase
   end

   // A byte store hits one lane; a halfword store hits the two lanes of the
   // half selected by off[1], taking the low or high byte of the store data.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic       w_hit;
      logic [7:0] w_new_byte;

      assign w_hit      = w_is_byte ? (i_off == 2'(gi)) : (i_off[1] == 1'(gi / 2));
      assign w_new_byte = w_is_byte ? i_wdata[7:0] : i_wdata[8 * (gi % 2) +: 8];
      assign o_store_word[8 * gi +: 8] = w_hit ? w_new_byte : i_word[8 * gi +: 8];
   end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Load/store bridge between the core execute stage and a word-wide synchronous
// RAM; one request at a time, read-modify-write for sub-word stores.
module lsu_mem_bridge
   import lsu_pkg::*;
#(
   parameter int RAM_WIDTH     = 32,
   parameter int RAM_ADDR_BITS = 9
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [2:0]               req_funct3,
   input  logic [RAM_WIDTH-1:0]     req_addr,
   input  logic [RAM_WIDTH-1:0]     req_wdata,
   output logic                     rsp_valid,
   output logic [RAM_WIDTH-1:0]     rsp_rdata,
   output logic                     rsp_error,
   output logic                     mem_enable,
   output logic                     mem_write_enable,
   output logic [RAM_ADDR_BITS-1:0] mem_address,
   output logic [RAM_WIDTH-1:0]     mem_wdata,
   input  logic [RAM_WIDTH-1:0]     mem_rdata
);

   lsu_state_t               r_state;
   lsu_state_t               w_state_next;
   logic [2:0]               r_funct3;
   logic [1:0]               r_off;
   logic [RAM_ADDR_BITS-1:0] r_word_addr;
   logic [15:0]              r_wdata;

   logic                     w_accept;
   logic                     w_error;
   logic [RAM_ADDR_BITS-1:0] w_req_word_addr;
   logic [31:0]              w_load_data;
   logic [31:0]              w_store_word;
   logic                     w_unused_addr_bits;

   // Address bits above the RAM's word range are dropped so accesses wrap.
   assign w_unused_addr_bits = ^req_addr[RAM_WIDTH-1:RAM_ADDR_BITS+2];
   assign w_req_word_addr    = req_addr[RAM_ADDR_BITS+1:2];
   assign w_error  = illegal_funct3(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
   assign w_accept = req_valid && (r_state == ST_IDLE) && !reset;

   lsu_align u_align (
      .i_word       (mem_rdata),
      .i_off        (r_off),
      .i_funct3     (r_funct3),
      .i_wdata      (r_wdata),
      .o_load_data  (w_load_data),
      .o_store_word (w_store_word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_funct3    <= 3'b000;
         r_off       <= 2'b00;
         r_word_addr <= '0;
         r_wdata     <= 16'h0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_funct3    <= req_funct3;
            r_off       <= req_addr[1:0];
            r_word_addr <= w_req_word_addr;
            r_wdata     <= req_wdata[15:0];
         end
      end
   end

   // Reset overrides every output combinationally so an in-flight RMW write
   // or response is suppressed in the very cycle reset is asserted.
   always_comb begin
      w_state_next     = r_state;
      req_ready        = 1'b0;
      rsp_valid        = 1'b0;
      rsp_error        = 1'b0;
      rsp_rdata        = '0;
      mem_enable       = 1'b0;
      mem_write_enable = 1'b0;
      mem_address      = r_word_addr;
      mem_wdata        = '0;

      if (reset) begin
         w_state_next = ST_IDLE;
         mem_address  = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               req_ready = 1'b1;
               if (w_accept) begin
                  mem_address = w_req_word_addr;
                  if (w_error) begin
                     w_state_next = ST_ERR;
                  end else begin
                     mem_enable = 1'b1;
                     if (!req_we) begin
                        w_state_next = ST_LOAD;
                     end else if (req_funct3 == F3_W) begin
                        mem_write_enable = 1'b1;
                        mem_wdata        = req_wdata;
                        w_state_next     = ST_RESP;
                     end else begin
                        w_state_next = ST_RMW;
                     end
                  end
               end
            end
            ST_LOAD: begin
               rsp_valid    = 1'b1;
               rsp_rdata    = w_load_data;
               w_state_next = ST_IDLE;
            end
            ST_RMW: begin
               mem_enable       = 1'b1;
               mem_write_enable = 1'b1;
               mem_wdata        = w_store_word;
               w_state_next     = ST_RESP;
            end
            ST_RESP: begin
               rsp_valid    = 1'b1;
               w_state_next = ST_IDLE;
            end
            ST_ERR: begin
               rsp_valid    = 1'b1;
               rsp_error    = 1'b1;
               w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed bench for lsu_mem_bridge: a synchronous RAM, a byte-level reference
// model of each access, and a per-cycle compare against the model's schedule.
module tb_lsu_mem_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_error;
   logic [31:0] rsp_rdata;
   logic        mem_enable, mem_write_enable;
   logic [8:0]  mem_address;
   logic [31:0] mem_wdata, mem_rdata;

   lsu_mem_bridge #(.RAM_WIDTH(32), .RAM_ADDR_BITS(9)) dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_we           (req_we),
      .req_funct3       (req_funct3),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .rsp_valid        (rsp_valid),
      .rsp_rdata        (rsp_rdata),
      .rsp_error        (rsp_error),
      .mem_enable       (mem_enable),
      .mem_write_enable (mem_write_enable),
      .mem_address      (mem_address),
      .mem_wdata        (mem_wdata),
      .mem_rdata        (mem_rdata)
   );

   always #5 clk = ~clk;

   // RAM with registered read; a bench-side preload port seeds word contents.
   logic [31:0] ram [512];
   logic        pl_en = 1'b0;
   logic [8:0]  pl_addr = 9'd0;
   logic [31:0] pl_data = 32'h0;

   always @(posedge clk) begin
      if (pl_en)
         ram[pl_addr] <= pl_data;
      else if (mem_enable) begin
         if (mem_write_enable)
            ram[mem_address] <= mem_wdata;
         else
            mem_rdata <= ram[mem_address];
      end
   end

   logic [31:0] shadow [512];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   // Expected schedule of the transaction in flight, in cycle numbers.
   int          exp_rsp_cyc = -1, exp_rd_cyc = -1, exp_wr_cyc = -1;
   int          busy_lo = -1, busy_hi = -2;
   logic        exp_err = 1'b0;
   logic [31:0] exp_rdata = 32'h0, exp_newword = 32'h0;
   logic [8:0]  exp_waddr = 9'h0;
   logic [31:0] last_rdata = 32'h0;
   logic        last_err = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Size/offset arithmetic straight from the ISA: size = 2**funct3[1:0] bytes.
   function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] word,
                                 output logic err, output logic [31:0] rd, output logic [31:0] nw);
      int          size, off;
      logic [31:0] mask;
      logic        legal;
      legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      size  = 1 << f3[1:0];
      off   = int'(addr[1:0]);
      err   = !legal || (off % size != 0);
      mask  = (size >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
      rd    = (word >> (8 * off)) & mask;
      if (!f3[2] && size < 4 && rd[8 * size - 1])
         rd = rd | ~mask;
      nw = word;
      for (int i = 0; i < size && off + i < 4; i++)
         nw[8 * (off + i) +: 8] = wdata[8 * i +: 8];
   endfunction

   always @(negedge clk) begin
      chk("req_ready", 32'(req_ready), 32'(!reset && !(cyc >= busy_lo && cyc <= busy_hi)));
      chk("rsp_valid", 32'(rsp_valid), 32'(cyc == exp_rsp_cyc));
      if (cyc == exp_rsp_cyc) begin
         chk("rsp_error", 32'(rsp_error), 32'(exp_err));
         chk("rsp_rdata", rsp_rdata, exp_rdata);
      end else begin
         chk("rsp_rdata_idle", rsp_rdata, 32'h0);
      end
      chk("mem_enable", 32'(mem_enable), 32'(cyc == exp_rd_cyc || cyc == exp_wr_cyc));
      chk("mem_write_enable", 32'(mem_write_enable), 32'(cyc == exp_wr_cyc));
      if (cyc == exp_rd_cyc || cyc == exp_wr_cyc)
         chk("mem_address", 32'(mem_address), 32'(exp_waddr));
      chk("mem_wdata", mem_wdata, (cyc == exp_wr_cyc) ? exp_newword : 32'h0);
      if (rsp_valid) begin
         last_rdata <= rsp_rdata;
         last_err   <= rsp_error;
      end
   end

   task automatic preload(input logic [8:0] widx, input logic [31:0] val);
      @(posedge clk); #1;
      pl_en = 1'b1; pl_addr = widx; pl_data = val;
      shadow[widx] = val;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit hold, input bit abort);
      int          k, lat;
      logic        err;
      logic [31:0] rd, nw;
      logic [8:0]  widx;
      widx = addr[10:2];
      model(we, f3, addr, wdata, shadow[widx], err, rd, nw);
      lat = (err || !we || f3 == 3'd2) ? 1 : 2;
      @(posedge clk); #1;
      k           = cyc;
      exp_err     = err;
      exp_rdata   = (err || we) ? 32'h0 : rd;
      exp_newword = nw;
      exp_waddr   = widx;
      exp_rd_cyc  = (err || (we && f3 == 3'd2)) ? -1 : k;
      exp_wr_cyc  = (err || !we) ? -1 : ((f3 == 3'd2) ? k : k + 1);
      exp_rsp_cyc = k + lat;
      busy_lo     = k + 1;
      busy_hi     = k + lat;
      if (abort) begin
         exp_wr_cyc  = -1;
         exp_rsp_cyc = -1;
         busy_hi     = k + 1;
      end
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      @(posedge clk); #1;
      if (!hold) begin
         req_valid  = 1'b0;
         req_we     = 1'($urandom);
         req_funct3 = 3'($urandom);
         req_addr   = $urandom;
         req_wdata  = $urandom;
      end
      if (abort) begin
         reset = 1'b1;
         @(posedge clk); #1;
         reset = 1'b0;
      end else begin
         repeat (lat - 1) begin
            @(posedge clk); #1;
         end
         req_valid = 1'b0;
         if (!err && we)
            shadow[widx] = nw;
      end
      @(posedge clk); #1;
      chk("mem_word", ram[widx], shadow[widx]);
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          pre;
      bit          hold;
      bit          abort;
      logic        err;
      logic [31:0] rdata;
      logic [31:0] word;
   } txn_t;

   txn_t tbl [17];

   initial begin
      tbl = '{
         '{1'b0, 3'b000, 32'h11,  32'h0,        1, 0, 0, 1'b0, 32'hFFFF_FFF2, 32'h8081_F2A5},
         '{1'b0, 3'b100, 32'h13,  32'h0,        1, 0, 0, 1'b0, 32'h0000_0080, 32'h8081_F2A5},
         '{1'b0, 3'b001, 32'h12,  32'h0,        1, 0, 0, 1'b0, 32'hFFFF_8081, 32'h8081_F2A5},
         '{1'b0, 3'b101, 32'h10,  32'h0,        1, 0, 0, 1'b0, 32'h0000_F2A5, 32'h8081_F2A5},
         '{1'b1, 3'b000, 32'h12,  32'h1234_563C, 1, 0, 0, 1'b0, 32'h0,          32'h803C_F2A5},
         '{1'b1, 3'b010, 32'h10,  32'hDEAD_BEEF, 1, 0, 0, 1'b0, 32'h0,          32'hDEAD_BEEF},
         '{1'b0, 3'b010, 32'h10,  32'h0,        0, 0, 0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF},
         '{1'b1, 3'b001, 32'h12,  32'h0000_BEEF, 1, 0, 0, 1'b0, 32'h0,          32'hBEEF_F2A5},
         '{1'b0, 3'b010, 32'h12,  32'h0,        1, 0, 0, 1'b1, 32'h0,          32'h8081_F2A5},
         '{1'b1, 3'b001, 32'h13,  32'hFFFF_FFFF, 1, 0, 0, 1'b1, 32'h0,          32'h8081_F2A5},
         '{1'b0, 3'b011, 32'h10,  32'h0,        1, 0, 0, 1'b1, 32'h0,          32'h8081_F2A5},
         '{1'b1, 3'b100, 32'h10,  32'h0000_0055, 1, 0, 0, 1'b1, 32'h0,          32'h8081_F2A5},
         '{1'b0, 3'b010, 32'h810, 32'h0,        1, 0, 0, 1'b0, 32'h8081_F2A5, 32'h8081_F2A5},
         '{1'b1, 3'b001, 32'h812, 32'h0000_1234, 1, 0, 0, 1'b0, 32'h0,          32'h1234_F2A5},
         '{1'b0, 3'b010, 32'h10,  32'h0,        1, 1, 0, 1'b0, 32'h8081_F2A5, 32'h8081_F2A5},
         '{1'b1, 3'b000, 32'h11,  32'h0000_0077, 1, 1, 0, 1'b0, 32'h0,          32'h8081_77A5},
         '{1'b1, 3'b000, 32'h10,  32'h0000_00AA, 1, 0, 1, 1'b0, 32'h0,          32'h8081_F2A5}
      };

      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0;
      @(posedge clk); #1;
      chk("reset_req_ready", 32'(req_ready), 32'h0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("reset_mem_address", 32'(mem_address), 32'h0);
      chk("reset_mem_wdata", mem_wdata, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("post_reset_req_ready", 32'(req_ready), 32'h1);
      chk("post_reset_mem_address", 32'(mem_address), 32'h0);

      for (int i = 0; i < 17; i++) begin
         if (tbl[i].pre)
            preload(9'd4, 32'h8081_F2A5);
         do_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].hold, tbl[i].abort);
         chk($sformatf("txn%0d_word", i), ram[4], tbl[i].word);
         if (!tbl[i].abort) begin
            chk($sformatf("txn%0d_rdata", i), last_rdata, tbl[i].rdata);
            chk($sformatf("txn%0d_error", i), 32'(last_err), 32'(tbl[i].err));
         end
         $display("txn %0d: we=%0b f3=%03b addr=%h wdata=%h -> rdata=%h err=%0b word=%h",
                  i, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, last_rdata, last_err, ram[4]);
      end

      repeat (3) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_mem_bridge.md
# lsu_mem_bridge

Load/store bridge between the RV32I core's execute stage and the word-wide synchronous `data_memory`. It accepts one load or store request at a time and performs the memory access. For loads it extracts the byte or halfword and sign/zero-extends it. For byte/halfword stores it performs a read-modify-write, because `data_memory` has only a single full-word `write_enable`. Misaligned or illegal accesses are reported to the core and never touch memory.

## Interface
Parameters:
- `RAM_WIDTH`, 32, data/address width of the core side. Only 32 is supported.
- `RAM_ADDR_BITS`, 9, word-address width of `data_memory`.

Ports:
- `clk`, in, 1, single clock, rising edge.
- `reset`, in, 1, synchronous, active-high.
- `req_valid`, in, 1, core presents a request.
- `req_ready`, out, 1, bridge can accept a request. A request is accepted when `req_valid && req_ready`.
- `req_we`, in, 1, 1 = store, 0 = load.
- `req_funct3`, in, 3, RV32I funct3 of the load/store.
- `req_addr`, in, RAM_WIDTH, byte address from the ALU.
- `req_wdata`, in, RAM_WIDTH, store data (rs2).
- `rsp_valid`, out, 1, one-cycle completion pulse.
- `rsp_rdata`, out, RAM_WIDTH, extended load result. It is 0 for stores, for errors, and whenever `rsp_valid` = 0.
- `rsp_error`, out, 1, misaligned or illegal funct3. Valid only with `rsp_valid`.
- `mem_enable`, out, 1, maps to `data_memory.ram_enable`.
- `mem_write_enable`, out, 1, full-word write strobe.
- `mem_address`, out, RAM_ADDR_BITS, word address. Equals `req_addr[RAM_ADDR_BITS+1:2]`; higher address bits are ignored, so addresses wrap.
- `mem_wdata`, out, RAM_WIDTH, word to write.
- `mem_rdata`, in, RAM_WIDTH, read data. Valid one cycle after a read cycle, when `mem_enable` = 1 and `mem_write_enable` = 0.

## Operation
- Legal funct3 values:
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
  - Anything else is illegal.
- Misaligned accesses: halfword with `addr[0]` = 1; word with `addr[1:0]` ≠ 0.
- Request fields are latched on acceptance. The core may change its inputs afterwards.
- States:
  - IDLE: `req_ready` = 1. On accept:
    - error → ERR, with no memory access;
    - load → drive a read, go to LOAD;
    - SW → drive the write this cycle, go to RESP;
    - SB/SH → drive a read, go to RMW.
  - LOAD: select the lane from `mem_rdata` using `addr[1:0]`, extend per funct3, assert `rsp_valid`. → IDLE.
  - RMW: merge the latched store byte(s) into `mem_rdata` at the lane given by `addr[1:0]`. Drive `mem_write_enable` = 1 with the same `mem_address`. → RESP.
  - RESP: `rsp_valid` = 1, `rsp_rdata` = 0. → IDLE.
  - ERR: `rsp_valid` = 1, `rsp_error` = 1, `rsp_rdata` = 0. → IDLE.
- `req_ready` = 0 in every state other than IDLE, and while `reset` = 1.
- Memory-side outputs:
  - `mem_enable` and `mem_write_enable` are 0 in all cycles other than those listed above.
  - `mem_wdata` is 0 when not writing.
  - `mem_address` holds the latched word address while busy.

## Timing
- Reset values:
  - State = IDLE.
  - `req_ready`, `rsp_valid`, `rsp_error`, `mem_enable`, `mem_write_enable` = 0.
  - `rsp_rdata`, `mem_address`, `mem_wdata` = 0.
- Latency from the acceptance edge to the `rsp_valid` cycle:
  - 1 cycle: loads, SW, errors.
  - 2 cycles: SB/SH.
- Throughput: one request every 2 cycles (loads/SW/errors) or every 3 cycles (SB/SH).
- The memory-side outputs for the access cycle are combinational from the request in IDLE. The memory therefore samples them on the acceptance edge.
- Reset asserted in any state: return to IDLE on the next edge. A pending RMW write never occurs. No `rsp_valid` is produced for the aborted request.
- `req_valid` while busy is ignored, not queued.

## Structure
- Package `lsu_pkg`:
  - funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - state encoding (IDLE, LOAD, RMW, RESP, ERR);
  - the `misaligned` check function.
- Sub-module `lsu_align`, purely combinational, two functions:
  - load extract/extend: (word, `addr[1:0]`, funct3) → result;
  - store merge: (old word, wdata, `addr[1:0]`, funct3) → new word.
- The top contains the FSM, the request latch and the memory-port drive.

## Test plan
Preload word 4 (byte address 0x10) with 0x8081F2A5 before each scenario.
- LB 0x11 → `rsp_valid` 1 cycle after accept, `rsp_rdata` = 0xFFFFFFF2. LBU 0x13 → 0x00000080. LH 0x12 → 0xFFFF8081. LHU 0x10 → 0x0000F2A5.
- SB 0x12, wdata 0x1234563C → exactly one write cycle, word becomes 0x803CF2A5, `rsp_valid` 2 cycles after accept, `rsp_rdata` = 0.
- SW 0x10, 0xDEADBEEF → write on the accept cycle, `rsp_valid` the next cycle, a subsequent LW 0x10 returns 0xDEADBEEF. SH 0x12, 0xBEEF → word 0xBEEFF2A5.
- Error cases, each giving `rsp_error` = 1, `rsp_rdata` = 0, `mem_enable` never 1, memory unchanged:
  - LW 0x12;
  - SH 0x13;
  - load with funct3 = 011.
- Address 0x810 with `RAM_ADDR_BITS` = 9 → wraps to word 4. Holding `req_valid` high during LOAD/RMW/RESP → no second accept until IDLE.
- `reset` asserted on the RMW cycle of SB 0x10 → no `mem_write_enable`, word stays 0x8081F2A5, no `rsp_valid`, `req_ready` = 1 on the first cycle after `reset` deasserts.
